// File: rtl/rca_accum_ctrl.sv
// Sequential multi-operand adder controller.
// Sums NOPS 4-bit unsigned operands over successive accept cycles using one
// 4-bit ripple-carry adder for the low nibble and a half-adder chain that
// increments the upper bits on carry-out. Operands arrive over a valid/ready
// input port and the sum leaves over a valid/ready output port.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[4];

endmodule

module rca_accum_ctrl #(
  parameter int NOPS = 3,
  parameter int SW   = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic          busy
);

  // Upper accumulator width; SW >= 5 keeps this at least one bit wide.
  localparam int HW = SW - 4;
  // Counter is wide enough to hold NOPS so cnt+1 never truncates.
  localparam int CW = $clog2(NOPS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NOPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [3:0]    acc_lo_r;
  logic [3:0]    acc_lo_s;
  logic [HW-1:0] acc_hi_r;
  logic [HW-1:0] acc_hi_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [3:0]    rca_sum_s;
  logic          rca_cout_s;

  // Half-adder chain: adds a single carry bit into the upper accumulator.
  function automatic logic [HW-1:0] ha_inc(input logic [HW-1:0] a, input logic cin);
    logic          c;
    logic [HW-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < HW; i++) begin
      s[i] = a[i] ^ c;
      c    = a[i] & c;
    end
    return s;
  endfunction

  rca4 u_rca (
    .a    (acc_lo_r),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (rca_sum_s),
    .cout (rca_cout_s)
  );

  // Next-state and datapath update; every branch assigns all next values.
  always_comb begin
    state_s  = state_r;
    acc_lo_s = acc_lo_r;
    acc_hi_s = acc_hi_r;
    cnt_s    = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_ACCUM;
          acc_lo_s = 4'd0;
          acc_hi_s = '0;
          cnt_s    = '0;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone means accept.
        if (in_valid) begin
          acc_lo_s = rca_sum_s;
          acc_hi_s = ha_inc(acc_hi_r, rca_cout_s);
          cnt_s    = cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_s = S_DONE;
          end else begin
            state_s = S_ACCUM;
          end
        end else begin
          state_s = S_ACCUM;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (start) begin
            // Restart immediately; clearing acc drops any stale carry.
            state_s  = S_ACCUM;
            acc_lo_s = 4'd0;
            acc_hi_s = '0;
            cnt_s    = '0;
          end else begin
            state_s  = S_IDLE;
          end
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s  = S_IDLE;
        acc_lo_s = 4'd0;
        acc_hi_s = '0;
        cnt_s    = '0;
      end
    endcase
  end

  // State and accumulator registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      acc_lo_r <= 4'd0;
      acc_hi_r <= '0;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_s;
      acc_lo_r <= acc_lo_s;
      acc_hi_r <= acc_hi_s;
      cnt_r    <= cnt_s;
    end
  end

  // Handshake outputs decode only from the state register.
  assign in_ready  = (state_r == S_ACCUM);
  assign out_valid = (state_r == S_DONE);
  assign busy      = (state_r == S_ACCUM) || (state_r == S_DONE);
  // Sum comes straight from the accumulator flops; it holds through IDLE.
  assign out_sum   = {acc_hi_r, acc_lo_r};

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Directed bench for rca_accum_ctrl (NOPS=3, SW=6) plus a NOPS=1 instance.

module tb_rca_accum_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic       busy;

  logic       start1;
  logic       in_valid1;
  logic       in_ready1;
  logic       out_valid1;
  logic       out_ready1;
  logic [4:0] out_sum1;
  logic       busy1;

  int vec_count = 0;
  int err_count = 0;

  rca_accum_ctrl #(.NOPS(3), .SW(6)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  rca_accum_ctrl #(.NOPS(1), .SW(5)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .busy      (busy1)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 4'd0;
    out_ready  = 1'b0;
    start1     = 1'b0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst1_out_sum", 32'(out_sum1), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // 4+5+6 = 15
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_ready0", 32'(in_ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send(4'd4);
    check("t1_ready1", 32'(in_ready), 32'd1);
    check("t1_valid1", 32'(out_valid), 32'd0);
    send(4'd5);
    check("t1_ready2", 32'(in_ready), 32'd1);
    send(4'd6);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_in_ready_done", 32'(in_ready), 32'd0);
    check("t1_sum", 32'(out_sum), 32'd15);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_sum_hold", 32'(out_sum), 32'd15);

    // 15+15+15 = 45, carries into upper bits
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd15);
    check("t2_partial1", 32'(out_sum), 32'd15);
    send(4'd15);
    check("t2_partial2", 32'(out_sum), 32'd30);
    send(4'd15);
    check("t2_sum", 32'(out_sum), 32'd45);
    check("t2_valid", 32'(out_valid), 32'd1);

    // Back-to-back restart from DONE: 1+2+3 = 6
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t3_accum_ready", 32'(in_ready), 32'd1);
    check("t3_valid_low", 32'(out_valid), 32'd0);
    check("t3_acc_clear", 32'(out_sum), 32'd0);
    send(4'd1);
    send(4'd2);
    send(4'd3);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_sum", 32'(out_sum), 32'd6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_idle", 32'(busy), 32'd0);

    // 7,9,2 with gaps, then backpressure: 18
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd7);
    tick();
    tick();
    check("t4_gap_sum", 32'(out_sum), 32'd7);
    check("t4_gap_ready", 32'(in_ready), 32'd1);
    send(4'd9);
    tick();
    tick();
    check("t4_gap_sum2", 32'(out_sum), 32'd16);
    send(4'd2);
    in_valid = 1'b1;
    in_data  = 4'd11;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_sum", 32'(out_sum), 32'd18);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
    check("t4_hold_sum_end", 32'(out_sum), 32'd18);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_idle", 32'(out_valid), 32'd0);

    // start during ACCUM is ignored: 1+2+3 = 6 after exactly 3 accepts
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd1);
    start = 1'b1;
    send(4'd2);
    start = 1'b0;
    check("t5_still_accum", 32'(in_ready), 32'd1);
    send(4'd3);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_sum", 32'(out_sum), 32'd6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset mid-operation, then 0+0+1 = 1
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd8);
    send(4'd9);
    check("t6_pre_rst_sum", 32'(out_sum), 32'd17);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_sum", 32'(out_sum), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(4'd0);
    send(4'd0);
    send(4'd1);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_sum", 32'(out_sum), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // NOPS=1: first accept goes straight to DONE
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1;
    in_data   = 4'd13;
    tick();
    in_valid1 = 1'b0;
    in_data   = 4'd0;
    check("n1_valid", 32'(out_valid1), 32'd1);
    check("n1_sum", 32'(out_sum1), 32'd13);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("n1_idle", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
